// File: rtl/status_reg.sv
// 6502 processor status register (P): flag update from ALU results, flag set/clear,
// PLP/RTI loads, BIT semantics, ALU carry-in polarity and one-instruction-delayed IRQ mask.
module status_reg #(
  parameter logic [7:0] RESET_P = 8'h24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       alu_sub,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [7:0] alu_res,
  input  logic       alu_cout,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       bit_op,
  input  logic [2:0] flag_cmd,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       load_fast,
  input  logic       instr_done,
  input  logic       brk_push,
  output logic [7:0] p_out,
  output logic       carry,
  output logic       alu_cin,
  output logic       decimal,
  output logic       irq_mask
);

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_CLC  = 3'd1,
    CMD_SEC  = 3'd2,
    CMD_CLI  = 3'd3,
    CMD_SEI  = 3'd4,
    CMD_CLV  = 3'd5,
    CMD_CLD  = 3'd6,
    CMD_SED  = 3'd7
  } flag_cmd_e;

  logic n_q, v_q, d_q, i_q, z_q, c_q, irq_mask_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d, irq_mask_d;
  logic overflow;
  logic res_zero;

  assign res_zero = (alu_res == 8'h00);

  // Signed overflow; subtract flips the sign test because B is effectively inverted.
  always_comb begin
    if (alu_sub) begin
      overflow = (alu_a[7] ^ alu_b[7]) & (alu_a[7] ^ alu_res[7]);
    end else begin
      overflow = ~(alu_a[7] ^ alu_b[7]) & (alu_a[7] ^ alu_res[7]);
    end
  end

  // Next flag values: load wins outright, then explicit flag commands, then arithmetic.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (load) begin
      n_d = load_data[7];
      v_d = load_data[6];
      d_d = load_data[3];
      i_d = load_data[2];
      z_d = load_data[1];
      c_d = load_data[0];
    end else begin
      if (bit_op) begin
        n_d = alu_b[7];
        v_d = alu_b[6];
        z_d = res_zero;
      end else begin
        if (upd_nz) begin
          n_d = alu_res[7];
          z_d = res_zero;
        end else begin
          n_d = n_q;
        end
        if (upd_v) begin
          v_d = overflow;
        end else begin
          v_d = v_q;
        end
      end
      // The ALU reports borrow on subtract; 6502 C means "no borrow".
      if (upd_c) begin
        c_d = alu_sub ? ~alu_cout : alu_cout;
      end else begin
        c_d = c_q;
      end
      case (flag_cmd_e'(flag_cmd))
        CMD_CLC: c_d = 1'b0;
        CMD_SEC: c_d = 1'b1;
        CMD_CLI: i_d = 1'b0;
        CMD_SEI: i_d = 1'b1;
        CMD_CLV: v_d = 1'b0;
        CMD_CLD: d_d = 1'b0;
        CMD_SED: d_d = 1'b1;
        default: c_d = c_d;
      endcase
    end
  end

  // IRQ mask samples the pre-edge I at instruction end, except RTI which applies at once.
  always_comb begin
    if (load && load_fast) begin
      irq_mask_d = load_data[2];
    end else if (instr_done) begin
      irq_mask_d = i_q;
    end else begin
      irq_mask_d = irq_mask_q;
    end
  end

  // Flag and IRQ-mask registers with synchronous reset and stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q        <= RESET_P[7];
      v_q        <= RESET_P[6];
      d_q        <= RESET_P[3];
      i_q        <= RESET_P[2];
      z_q        <= RESET_P[1];
      c_q        <= RESET_P[0];
      irq_mask_q <= 1'b1;
    end else if (en) begin
      n_q        <= n_d;
      v_q        <= v_d;
      d_q        <= d_d;
      i_q        <= i_d;
      z_q        <= z_d;
      c_q        <= c_d;
      irq_mask_q <= irq_mask_d;
    end else begin
      n_q        <= n_q;
      v_q        <= v_q;
      d_q        <= d_q;
      i_q        <= i_q;
      z_q        <= z_q;
      c_q        <= c_q;
      irq_mask_q <= irq_mask_q;
    end
  end

  assign p_out    = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
  assign carry    = c_q;
  assign decimal  = d_q;
  assign irq_mask = irq_mask_q;
  assign alu_cin  = alu_sub ? ~c_q : c_q;

endmodule

// File: tb/tb_status_reg.sv
// Directed, table-driven bench for status_reg with hand-computed expected P bytes.
module tb_status_reg;

  logic       clk;
  logic       reset, en, alu_sub, alu_cout, upd_nz, upd_c, upd_v, bit_op;
  logic [7:0] alu_a, alu_b, alu_res, load_data;
  logic [2:0] flag_cmd;
  logic       load, load_fast, instr_done, brk_push;
  logic [7:0] p_out;
  logic       carry, alu_cin, decimal, irq_mask;

  int checks = 0;
  int errors = 0;

  status_reg dut (
    .clk(clk), .reset(reset), .en(en), .alu_sub(alu_sub),
    .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res), .alu_cout(alu_cout),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_op(bit_op),
    .flag_cmd(flag_cmd), .load(load), .load_data(load_data), .load_fast(load_fast),
    .instr_done(instr_done), .brk_push(brk_push),
    .p_out(p_out), .carry(carry), .alu_cin(alu_cin), .decimal(decimal), .irq_mask(irq_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, en, sub;
    logic [7:0] a, b, r;
    logic       cout, nz, uc, uv, bitop;
    logic [2:0] cmd;
    logic       ld;
    logic [7:0] ldd;
    logic       fast, done, brk;
    logic [7:0] exp_p;
    logic       exp_irq, exp_cin;
  } vec_t;

  function automatic vec_t mk(string nm, logic rst, logic e, logic sub,
                              logic [7:0] a, logic [7:0] b, logic [7:0] r, logic cout,
                              logic nz, logic uc, logic uv, logic bitop, logic [2:0] cmd,
                              logic ld, logic [7:0] ldd, logic fast, logic done, logic brk,
                              logic [7:0] ep, logic eirq, logic ecin);
    vec_t t;
    t.name = nm; t.rst = rst; t.en = e; t.sub = sub;
    t.a = a; t.b = b; t.r = r; t.cout = cout;
    t.nz = nz; t.uc = uc; t.uv = uv; t.bitop = bitop; t.cmd = cmd;
    t.ld = ld; t.ldd = ldd; t.fast = fast; t.done = done; t.brk = brk;
    t.exp_p = ep; t.exp_irq = eirq; t.exp_cin = ecin;
    return t;
  endfunction

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic apply(vec_t t);
    reset = t.rst; en = t.en; alu_sub = t.sub;
    alu_a = t.a; alu_b = t.b; alu_res = t.r; alu_cout = t.cout;
    upd_nz = t.nz; upd_c = t.uc; upd_v = t.uv; bit_op = t.bitop; flag_cmd = t.cmd;
    load = t.ld; load_data = t.ldd; load_fast = t.fast; instr_done = t.done; brk_push = t.brk;
    @(posedge clk);
    #1;
    chk({t.name, ".p_out"}, p_out, t.exp_p);
    chk({t.name, ".irq_mask"}, {7'd0, irq_mask}, {7'd0, t.exp_irq});
    chk({t.name, ".alu_cin"}, {7'd0, alu_cin}, {7'd0, t.exp_cin});
    chk({t.name, ".carry"}, {7'd0, carry}, {7'd0, t.exp_p[0]});
    chk({t.name, ".decimal"}, {7'd0, decimal}, {7'd0, t.exp_p[3]});
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b0; en = 1'b0; alu_sub = 1'b0; alu_a = 8'h00; alu_b = 8'h00; alu_res = 8'h00;
    alu_cout = 1'b0; upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0; bit_op = 1'b0;
    flag_cmd = 3'd0; load = 1'b0; load_data = 8'h00; load_fast = 1'b0;
    instr_done = 1'b0; brk_push = 1'b0;

    //             name         rst en sub  a      b      r      co nz uc uv bo cmd  ld ldd    fs dn bk  exp_p  irq cin
    tbl.push_back(mk("rst_add",  1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0, 0, 0, 8'h24, 1, 0));
    tbl.push_back(mk("rst_sub",  1, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0, 0, 0, 8'h24, 1, 1));
    tbl.push_back(mk("add_ovf",  0, 1, 0, 8'h50, 8'h50, 8'hA0, 0, 1, 1, 1, 0, 3'd0, 0, 8'h00, 0, 0, 0, 8'hE4, 1, 0));
    tbl.push_back(mk("sub_eq",   0, 1, 1, 8'h05, 8'h05, 8'h00, 0, 1, 1, 1, 0, 3'd0, 0, 8'h00, 0, 0, 0, 8'h27, 1, 0));
    tbl.push_back(mk("sub_brw",  0, 1, 1, 8'h05, 8'h06, 8'hFF, 1, 1, 1, 1, 0, 3'd0, 0, 8'h00, 0, 0, 0, 8'hA4, 1, 1));
    tbl.push_back(mk("sec_ovr",  0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 0, 3'd2, 0, 8'h00, 0, 0, 0, 8'hA5, 1, 1));
    tbl.push_back(mk("set_v",    0, 1, 0, 8'h50, 8'h50, 8'hA0, 0, 0, 0, 1, 0, 3'd0, 0, 8'h00, 0, 0, 0, 8'hE5, 1, 1));
    tbl.push_back(mk("clv_ovr",  0, 1, 0, 8'h80, 8'h80, 8'h00, 0, 1, 0, 1, 0, 3'd5, 0, 8'h00, 0, 0, 0, 8'h27, 1, 1));
    tbl.push_back(mk("bit_op",   0, 1, 0, 8'h00, 8'hC0, 8'h00, 0, 1, 0, 1, 1, 3'd0, 0, 8'h00, 0, 0, 0, 8'hE7, 1, 1));
    tbl.push_back(mk("sed",      0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd7, 0, 8'h00, 0, 0, 0, 8'hEF, 1, 1));
    tbl.push_back(mk("cld",      0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd6, 0, 8'h00, 0, 0, 0, 8'hE7, 1, 1));
    tbl.push_back(mk("clc",      0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd1, 0, 8'h00, 0, 0, 0, 8'hE6, 1, 0));
    tbl.push_back(mk("cli_done", 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd3, 0, 8'h00, 0, 1, 0, 8'hE2, 1, 0));
    tbl.push_back(mk("idle",     0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0, 0, 0, 8'hE2, 1, 0));
    tbl.push_back(mk("done_irq", 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0, 1, 0, 8'hE2, 0, 0));
    tbl.push_back(mk("sei_done", 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd4, 0, 8'h00, 0, 1, 0, 8'hE6, 0, 0));
    tbl.push_back(mk("done_sei", 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0, 1, 0, 8'hE6, 1, 0));
    tbl.push_back(mk("cli_2",    0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd3, 0, 8'h00, 0, 1, 0, 8'hE2, 1, 0));
    tbl.push_back(mk("done_2",   0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0, 1, 0, 8'hE2, 0, 0));
    tbl.push_back(mk("rti_fast", 0, 1, 0, 8'h00, 8'h00, 8'h80, 0, 1, 1, 1, 0, 3'd3, 1, 8'hFF, 1, 0, 0, 8'hEF, 1, 1));
    tbl.push_back(mk("brk_bit",  0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0, 0, 1, 8'hFF, 1, 1));
    tbl.push_back(mk("plp_slow", 0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0, 0, 3'd2, 1, 8'h30, 0, 0, 0, 8'h20, 1, 0));
    tbl.push_back(mk("plp_done", 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0, 1, 0, 8'h20, 0, 0));
    tbl.push_back(mk("stall",    0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 1, 1, 1, 0, 3'd7, 1, 8'hFF, 1, 1, 1, 8'h30, 0, 1));
    tbl.push_back(mk("rst_dom",  1, 1, 0, 8'h50, 8'h50, 8'hA0, 1, 1, 1, 1, 1, 3'd2, 1, 8'hFF, 1, 1, 0, 8'h24, 1, 0));
    tbl.push_back(mk("sec_3",    0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd2, 0, 8'h00, 0, 0, 0, 8'h25, 1, 1));
    tbl.push_back(mk("rst_stall",1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0, 0, 0, 8'h24, 1, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Stall in the middle of the IRQ-mask delay must not let the mask advance.
    apply(mk("seq_cli",  0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd3, 0, 8'h00, 0, 1, 0, 8'h20, 1, 0));
    apply(mk("seq_stl",  0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0, 1, 0, 8'h20, 1, 0));
    apply(mk("seq_nodn", 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0, 0, 0, 8'h20, 1, 0));
    apply(mk("seq_done", 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd0, 0, 8'h00, 0, 1, 0, 8'h20, 0, 0));
    // Reset mid-instruction restores the mask even after it was cleared.
    apply(mk("seq_rst",  1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3'd3, 0, 8'h00, 0, 1, 0, 8'h24, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_reg.md
Name: status_reg

Overview:
- 6502 processor status register (P). Sits directly downstream of the ALU.
- Consumes the ALU result and carry-out, derives N/Z/C/V, and handles the flag set/clear instructions, PLP/RTI loads and the BIT instruction.
- Feeds carry back into the ALU's carry input with the correct polarity for add or subtract.
- Provides the pushed P byte and a delayed IRQ mask to the control unit.

Parameters:
- RESET_P, 8'h24, P value after reset. Bit 5 reads 1; I=1; all other flags 0.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset, sampled on rising clk
- en  input  1  update enable; 0 = stall, all state held
- alu_sub  input  1  current ALU operation is subtract (SBC/CMP/CPX/CPY)
- alu_a  input  8  ALU A operand
- alu_b  input  8  ALU B operand (memory operand for BIT)
- alu_res  input  8  ALU result
- alu_cout  input  1  ALU carry-out (a borrow when alu_sub=1)
- upd_nz  input  1  update N and Z from alu_res
- upd_c  input  1  update C from alu_cout
- upd_v  input  1  update V from overflow
- bit_op  input  1  BIT semantics
- flag_cmd  input  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED
- load  input  1  load flags from load_data (PLP/RTI)
- load_data  input  8  byte pulled from the stack
- load_fast  input  1  with load: the IRQ mask follows I immediately (RTI)
- instr_done  input  1  last cycle of the current instruction
- brk_push  input  1  value driven on the B bit of p_out
- p_out  output  8  {N,V,1,brk_push,D,I,Z,C}, combinational from the flag registers
- carry  output  1  registered C flag
- alu_cin  output  1  ALU carry-in: C when alu_sub=0, ~C when alu_sub=1 (combinational)
- decimal  output  1  registered D flag
- irq_mask  output  1  registered, delayed I used for IRQ gating

Behaviour:
- State: flag registers N, V, D, I, Z, C, plus irq_mask. There is no register for bit 5 or B.
- Reset (synchronous, dominates en and all other inputs):
  - Flags load from RESET_P: N=V=D=Z=C=0, I=1.
  - irq_mask=1.
  - With brk_push=0, p_out=8'h24.
  - Reset asserted mid-instruction discards any pending update in that cycle.
- en=0: flags and irq_mask hold. p_out and alu_cin still track inputs combinationally.
- Flag update, rising edge with en=1. Priority is, per flag:
  1. load: N,V,D,I,Z,C <= load_data[7,6,3,2,1,0]. Bits 5 and 4 of load_data are ignored. All other controls are ignored that cycle.
  2. flag_cmd: the addressed flag is set or cleared. This overrides any arithmetic update of the same flag in that cycle. Flags it does not address may still update arithmetically.
  3. bit_op: N <= alu_b[7], V <= alu_b[6], Z <= (alu_res==0). Overrides upd_nz and upd_v.
  4. upd_nz: N <= alu_res[7], Z <= (alu_res==8'h00).
  5. upd_c: C <= alu_cout when alu_sub=0; C <= ~alu_cout when alu_sub=1, because the ALU reports borrow and 6502 C means "no borrow".
  6. upd_v, add: V <= ~(a7^b7) & (a7^r7). upd_v, subtract: V <= (a7^b7) & (a7^r7). Here a7/b7/r7 are the bit-7 values of alu_a, alu_b and alu_res.
- Latency: one clock from inputs to flag registers. carry, decimal and p_out reflect the new value in the cycle after the edge.
- irq_mask, en=1, no reset:
  - If load and load_fast: irq_mask <= load_data[2]. This has priority.
  - Else if instr_done: irq_mask <= the I value registered before this edge. A CLI/SEI/PLP in the final cycle therefore takes effect at the following instr_done, giving 6502 one-instruction IRQ latency.
  - Otherwise irq_mask holds.
- Decimal mode: D is stored and exported only. No BCD correction happens here.

Test Plan:
- Reset with brk_push=0 -> p_out=8'h24, irq_mask=1, carry=0, alu_cin=0 (alu_sub=0) and alu_cin=1 (alu_sub=1).
- ADD stimulus alu_a=8'h50, alu_b=8'h50, alu_res=8'hA0, alu_cout=0, upd_nz=upd_c=upd_v=1 -> next cycle N=1, V=1, Z=0, C=0, p_out=8'hE4.
- SUB stimulus alu_a=8'h05, alu_b=8'h05, alu_res=8'h00, alu_cout=0, alu_sub=1, all upd=1 -> C=1, Z=1, N=0, V=0. Then alu_sub=1 gives alu_cin=0. Repeat with alu_b=8'h06, alu_res=8'hFF, alu_cout=1 -> C=0, N=1.
- Same cycle: flag_cmd=SEC with upd_c=1 and alu_cout=0 -> C=1. Same cycle: flag_cmd=CLV with upd_v=1 and overflow present -> V=0. Same cycle: bit_op=1, alu_b=8'hC0, alu_res=8'h00 -> N=1, V=1, Z=1.
- IRQ mask delay:
  - CLI with instr_done=1 at edge k -> I=0, irq_mask stays 1.
  - Next instr_done -> irq_mask=0.
  - load=1, load_data=8'hFF, load_fast=1 -> p_out=8'hEF (brk_push=0) or 8'hFF (brk_push=1), irq_mask=1 on the same edge.
- Stall and reset: en=0 with load=1 -> no change. Then reset asserted together with upd_* and load -> p_out=8'h24, irq_mask=1.
